// File: rtl/clock_period_monitor.sv
// Measures the period and high time of an asynchronous slow clock in the fast Clock domain,
// emits synchronised rise/fall ticks and flags a stalled input.
module clock_period_monitor #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TIMEOUT     = 200000
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             SlowClock,
    input  logic             Enable,
    output logic             RiseTick,
    output logic             FallTick,
    output logic [CNT_W-1:0] Period,
    output logic [CNT_W-1:0] HighTime,
    output logic             PeriodValid,
    output logic             Timeout
);

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StMeasure
    } state_e;

    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   sync_lvl;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       hi_next_q;
    logic                   hi_seen_q;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // Synchroniser and edge ticks run independently of Enable and of the FSM state.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            sync_q   <= '0;
            prev_q   <= 1'b0;
            RiseTick <= 1'b0;
            FallTick <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], SlowClock};
            prev_q   <= sync_lvl;
            RiseTick <= sync_lvl & ~prev_q;
            FallTick <= ~sync_lvl & prev_q;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            hi_next_q   <= '0;
            hi_seen_q   <= 1'b0;
            Period      <= '0;
            HighTime    <= '0;
            PeriodValid <= 1'b0;
            Timeout     <= 1'b0;
        end else begin
            PeriodValid <= 1'b0;
            if (!Enable) begin
                state_q <= StIdle;
                cnt_q   <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        cnt_q   <= '0;
                        state_q <= StArm;
                    end
                    StArm: begin
                        cnt_q <= '0;
                        if (RiseTick) begin
                            cnt_q     <= CntOne;
                            hi_seen_q <= 1'b0;
                            state_q   <= StMeasure;
                        end
                    end
                    StMeasure: begin
                        // A rise landing on the timeout cycle still counts as a measurement.
                        if (RiseTick) begin
                            Period      <= cnt_q;
                            HighTime    <= hi_seen_q ? hi_next_q : '0;
                            PeriodValid <= 1'b1;
                            Timeout     <= 1'b0;
                            cnt_q       <= CntOne;
                            hi_seen_q   <= 1'b0;
                        end else if (cnt_q == TimeoutCnt) begin
                            Timeout <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= StArm;
                        end else begin
                            cnt_q <= cnt_q + CntOne;
                            if (FallTick) begin
                                hi_next_q <= cnt_q;
                                hi_seen_q <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule
